// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate register for the ALU stage.
// One bit per clock, start/busy/done handshake, carry and zero flags.
module shift_unit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ser_in,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done,
   output logic             carry,
   output logic             zero
);

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_ASR  = 3'b001;
   localparam logic [2:0] OP_LSL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_CLR  = 3'b101;
   localparam logic [2:0] OP_LOAD = 3'b110;
   localparam logic [2:0] OP_LSR  = 3'b111;

   localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
   localparam logic [AMT_W-1:0] CNT_ZERO = '0;

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic             r_carry;
   logic             r_zero;
   logic             r_busy;
   logic             r_done;
   logic [2:0]       r_op;
   logic [AMT_W-1:0] r_cnt;

   logic [2:0]       w_op;
   logic [WIDTH-1:0] w_step_d;
   logic             w_step_c;
   logic             w_is_shift;
   logic             w_accept;

   // One step of a shift/rotate op; non-shift ops pass data through.
   function automatic logic [WIDTH:0] f_step(
      input logic [2:0]       o,
      input logic [WIDTH-1:0] d,
      input logic             s,
      input logic             c
   );
      logic [WIDTH:0] res;
      res = {c, d};
      case (o)
         OP_ASR: res = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
         OP_LSL: res = {d[WIDTH-1], d[WIDTH-2:0], s};
         OP_ROR: res = {d[0], d[0], d[WIDTH-1:1]};
         OP_ROL: res = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
         OP_LSR: res = {d[0], s, d[WIDTH-1:1]};
         default: res = {c, d};
      endcase
      return res;
   endfunction

   function automatic logic f_shift_op(input logic [2:0] o);
      return (o == OP_ASR) || (o == OP_LSL) || (o == OP_ROR) ||
             (o == OP_ROL) || (o == OP_LSR);
   endfunction

   always_comb begin
      w_op       = (r_state == S_SHIFT) ? r_op : op;
      w_is_shift = f_shift_op(op);
      w_accept   = start && (r_state == S_IDLE);
      {w_step_c, w_step_d} = f_step(w_op, r_data, ser_in, r_carry);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_data  <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_op    <= OP_HOLD;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_is_shift) begin
                     if (amt == CNT_ZERO) begin
                        r_done <= 1'b1;
                     end else begin
                        r_data  <= w_step_d;
                        r_carry <= w_step_c;
                        r_zero  <= (w_step_d == '0);
                        if (amt == CNT_ONE) begin
                           r_done <= 1'b1;
                        end else begin
                           r_op    <= op;
                           r_cnt   <= amt - CNT_ONE;
                           r_busy  <= 1'b1;
                           r_state <= S_SHIFT;
                        end
                     end
                  end else begin
                     r_done <= 1'b1;
                     if (op == OP_CLR) begin
                        r_data  <= '0;
                        r_carry <= 1'b0;
                        r_zero  <= 1'b1;
                     end else if (op == OP_LOAD) begin
                        r_data  <= data_in;
                        r_carry <= 1'b0;
                        r_zero  <= (data_in == '0);
                     end
                  end
               end
            end
            S_SHIFT: begin
               r_data  <= w_step_d;
               r_carry <= w_step_c;
               r_zero  <= (w_step_d == '0);
               r_cnt   <= r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_out = r_data;
   assign busy     = r_busy;
   assign done     = r_done;
   assign carry    = r_carry;
   assign zero     = r_zero;

endmodule
